r2000_shifter_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational r2000_shifter. Performs logical left, logical right, arithmetic right, rotate-left and rotate-right on a DW-bit operand. The log2(DW) barrel levels are split across STAGES register stages with valid/ready flow control. A user tag travels with each operation. Intended for the multi-cycle datapath, where the shift path must not limit the clock period.

---
 rtl/r2000_shifter_pipe.sv | 132 +++++++++++++
 tb/tb_r2000_shifter_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2000_shifter_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready flow control.
// The log2(DW) shift levels are spread evenly over STAGES register stages.
module r2000_shifter_pipe #(
  parameter int unsigned DW     = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TW     = 4
) (
  input  logic                  CLK_i,
  input  logic                  RST_i,
  input  logic                  VALID_i,
  output logic                  READY_o,
  input  logic [DW-1:0]         A_i,
  input  logic [$clog2(DW)-1:0] SH_i,
  input  logic [2:0]            MODE_i,
  input  logic [TW-1:0]         TAG_i,
  output logic                  VALID_o,
  input  logic                  READY_i,
  output logic [DW-1:0]         G_o,
  output logic [TW-1:0]         TAG_o,
  output logic                  ERR_o
);

  localparam int unsigned LW   = $clog2(DW);
  localparam int unsigned LPS  = (LW + STAGES - 1) / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  localparam logic [2:0] MODE_SLL = 3'd0;
  localparam logic [2:0] MODE_SRL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  // One barrel level: shift/rotate by n; reserved modes pass data through.
  function automatic logic [DW-1:0] shift_one(input logic [DW-1:0] d, input int unsigned n,
                                              input logic [2:0] mode, input logic fill);
    logic [DW-1:0] r;
    r = d;
    case (mode)
      MODE_SLL: r = d << n;
      MODE_SRL: r = d >> n;
      MODE_SRA: r = (d >> n) | (fill ? ~({DW{1'b1}} >> n) : {DW{1'b0}});
      MODE_ROL: r = (d << n) | (d >> (DW - n));
      MODE_ROR: r = (d >> n) | (d << (DW - n));
      default:  r = d;
    endcase
    return r;
  endfunction

  // Apply the levels owned by the stage starting at level lo.
  function automatic logic [DW-1:0] shift_levels(input logic [DW-1:0] d, input logic [LW-1:0] sh,
                                                 input logic [2:0] mode, input logic fill,
                                                 input int unsigned lo);
    logic [DW-1:0] r;
    r = d;
    for (int k = 0; k < LW; k++) begin
      if (k >= lo && k < lo + LPS && sh[k]) r = shift_one(r, 1 << k, mode, fill);
    end
    return r;
  endfunction

  logic [STAGES-1:0]           vld_q, vld_in, adv;
  logic [STAGES-1:0][DW-1:0]   data_q, data_in, data_nx;
  logic [STAGES-1:0][LW-1:0]   sh_q, sh_in;
  logic [STAGES-1:0][2:0]      mode_q, mode_in;
  logic [STAGES-1:0][TW-1:0]   tag_q, tag_in;
  logic [STAGES-1:0]           fill_q, fill_in, err_q, err_in;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign vld_in[s]  = VALID_i;
      assign data_in[s] = A_i;
      assign sh_in[s]   = SH_i;
      assign mode_in[s] = MODE_i;
      assign tag_in[s]  = TAG_i;
      assign fill_in[s] = A_i[DW-1];
      assign err_in[s]  = (MODE_i > MODE_ROR);
    end else begin : g_rest
      assign vld_in[s]  = vld_q[s-1];
      assign data_in[s] = data_q[s-1];
      assign sh_in[s]   = sh_q[s-1];
      assign mode_in[s] = mode_q[s-1];
      assign tag_in[s]  = tag_q[s-1];
      assign fill_in[s] = fill_q[s-1];
      assign err_in[s]  = err_q[s-1];
    end
    assign data_nx[s] = shift_levels(data_in[s], sh_in[s], mode_in[s], fill_in[s], s * LPS);
  end

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv       = '0;
    adv[LAST] = !vld_q[LAST] || READY_i;
    for (int s = int'(LAST) - 1; s >= 0; s--) adv[s] = !vld_q[s] || adv[s+1];
  end

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      vld_q  <= '0;
      data_q <= '0;
      sh_q   <= '0;
      mode_q <= '0;
      tag_q  <= '0;
      fill_q <= '0;
      err_q  <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          vld_q[s] <= vld_in[s];
          // Bubbles leave the payload untouched so outputs hold while idle.
          if (vld_in[s]) begin
            data_q[s] <= data_nx[s];
            sh_q[s]   <= sh_in[s];
            mode_q[s] <= mode_in[s];
            tag_q[s]  <= tag_in[s];
            fill_q[s] <= fill_in[s];
            err_q[s]  <= err_in[s];
          end
        end
      end
    end
  end

  assign READY_o = adv[0];
  assign VALID_o = vld_q[LAST];
  assign G_o     = data_q[LAST];
  assign TAG_o   = tag_q[LAST];
  assign ERR_o   = err_q[LAST];

  logic unused;
  assign unused = ^{sh_q[LAST], mode_q[LAST], fill_q[LAST]};

endmodule

// File: tb/tb_r2000_shifter_pipe.sv
// Self-checking bench for r2000_shifter_pipe (DW=32, STAGES=2): vector table,
// scoreboard of expected results, and hand sequences for stall/reset cases.
module tb_r2000_shifter_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TW = 4;
  localparam int unsigned LW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld_i = 1'b0, rdy_o, vld_o, rdy_i = 1'b1, err_o;
  logic [DW-1:0] a_i = '0, g_o;
  logic [LW-1:0] sh_i = '0;
  logic [2:0]    mode_i = '0;
  logic [TW-1:0] tag_i = '0, tag_o;

  r2000_shifter_pipe #(.DW(DW), .STAGES(STAGES), .TW(TW)) dut (
    .CLK_i(clk), .RST_i(rst), .VALID_i(vld_i), .READY_o(rdy_o), .A_i(a_i), .SH_i(sh_i),
    .MODE_i(mode_i), .TAG_i(tag_i), .VALID_o(vld_o), .READY_i(rdy_i), .G_o(g_o),
    .TAG_o(tag_o), .ERR_o(err_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] g;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [LW-1:0] sh;
    logic [2:0]    mode;
    logic [DW-1:0] g;
    logic          err;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, fails = 0, n_out = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model written independently of the RTL level structure.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [LW-1:0] sh,
                                          input logic [2:0] mode);
    logic [2*DW-1:0] w;
    case (mode)
      3'd0: return a << sh;
      3'd1: return a >> sh;
      3'd2: return $signed(a) >>> sh;
      3'd3: begin w = {a, a} << sh; return w[2*DW-1:DW]; end
      3'd4: begin w = {a, a} >> sh; return w[DW-1:0]; end
      default: return a;
    endcase
  endfunction

  // Output monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    exp_t e;
    if (vld_o && rdy_i) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_output: got tag %0h g 0x%0h, expected no result", tag_o, g_o);
      end else begin
        e = sb.pop_front();
        check("result_g", 64'(g_o), 64'(e.g));
        check("result_tag", 64'(tag_o), 64'(e.tag));
        check("result_err", 64'(err_o), 64'(e.err));
      end
    end
  end

  // Present one op from just after a rising edge; returns #1 after its accept edge.
  task automatic send(input logic [DW-1:0] a, input logic [LW-1:0] sh, input logic [2:0] mode,
                      input logic [TW-1:0] tag, input logic [DW-1:0] g, input logic err);
    int w = 0;
    a_i = a; sh_i = sh; mode_i = mode; tag_i = tag; vld_i = 1'b1;
    @(negedge clk);
    while (!rdy_o && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!rdy_o) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got READY_o=0 for 50 cycles, expected 1");
    end else begin
      sb.push_back('{g: g, tag: tag, err: err});
    end
    @(posedge clk);
    #1 vld_i = 1'b0;
  endtask

  task automatic send_model(input logic [DW-1:0] a, input logic [LW-1:0] sh,
                            input logic [2:0] mode, input logic [TW-1:0] tag);
    send(a, sh, mode, tag, model(a, sh, mode), mode > 3'd4);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vt[$];
  logic saw_stall;
  logic rand_done;
  int   n0, t0;

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt = '{
      '{32'h0000_8A5F, 5'd1,  3'b000, 32'h0001_14BE, 1'b0},
      '{32'h0000_8A5F, 5'd2,  3'b001, 32'h0000_2297, 1'b0},
      '{32'h0000_8A5F, 5'd0,  3'b000, 32'h0000_8A5F, 1'b0},
      '{32'h8E93_C2A1, 5'd5,  3'b010, 32'hFC74_9E15, 1'b0},
      '{32'h8E93_C2A1, 5'd5,  3'b001, 32'h0474_9E15, 1'b0},
      '{32'h8E93_C2A1, 5'd5,  3'b000, 32'hD278_5420, 1'b0},
      '{32'h7E93_C2A1, 5'd12, 3'b100, 32'h2A17_E93C, 1'b0},
      '{32'h7E93_C2A1, 5'd4,  3'b011, 32'hE93C_2A17, 1'b0},
      '{32'h7E93_C2A1, 5'd4,  3'b111, 32'h7E93_C2A1, 1'b1},
      '{32'h8000_0001, 5'd31, 3'b000, 32'h8000_0000, 1'b0},
      '{32'h8000_0001, 5'd31, 3'b001, 32'h0000_0001, 1'b0},
      '{32'h8000_0001, 5'd31, 3'b010, 32'hFFFF_FFFF, 1'b0},
      '{32'h8000_0001, 5'd31, 3'b011, 32'hC000_0000, 1'b0},
      '{32'h8000_0001, 5'd31, 3'b100, 32'h0000_0003, 1'b0},
      '{32'h8E93_C2A1, 5'd0,  3'b010, 32'h8E93_C2A1, 1'b0},
      '{32'h8E93_C2A1, 5'd0,  3'b100, 32'h8E93_C2A1, 1'b0},
      '{32'h1234_5678, 5'd7,  3'b101, 32'h1234_5678, 1'b1},
      '{32'h1234_5678, 5'd9,  3'b110, 32'h1234_5678, 1'b1}
    };

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(vld_o), 64'd0);
    check("reset_g", 64'(g_o), 64'd0);
    check("reset_tag", 64'(tag_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_reset", 64'(rdy_o), 64'd1);

    // Latency: result visible after the second rising edge counting the accept edge
    send(32'h0000_8A5F, 5'd1, 3'b000, 4'hA, 32'h0001_14BE, 1'b0);
    check("latency_not_early", 64'(vld_o), 64'd0);
    @(posedge clk);
    #1;
    check("latency_valid", 64'(vld_o), 64'd1);
    check("latency_g", 64'(g_o), 64'h0001_14BE);
    drain();

    // Vector table, issued back to back
    for (int i = 0; i < vt.size(); i++)
      send(vt[i].a, vt[i].sh, vt[i].mode, TW'(i), vt[i].g, vt[i].err);
    drain();

    // Back-to-back with READY_i low for cycles 3..6
    n0 = n_out;
    saw_stall = 1'b0;
    fork
      for (int i = 0; i < 8; i++)
        send_model($urandom(), LW'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), TW'(i));
      begin
        repeat (3) @(posedge clk);
        #1 rdy_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rdy_i = 1'b1;
      end
      repeat (12) @(negedge clk) if (!rdy_o) saw_stall = 1'b1;
    join
    drain();
    check("bp_ready_dropped", 64'(saw_stall), 64'd1);
    check("bp_out_count", 64'(n_out - n0), 64'd8);

    // Full pipe: simultaneous in/out sustains one op per cycle
    rdy_i = 1'b0;
    send_model(32'hDEAD_BEEF, 5'd3, 3'b011, 4'h1);
    send_model(32'hCAFE_F00D, 5'd17, 3'b010, 4'h2);
    @(negedge clk) check("full_ready_low", 64'(rdy_o), 64'd0);
    @(posedge clk);
    #1 rdy_i = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      send_model($urandom(), LW'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), TW'(3 + i));
      check("full_valid_held", 64'(vld_o), 64'd1);
    end
    check("full_throughput_cycles", 64'(cyc - t0), 64'd4);
    rdy_i = 1'b0;
    @(negedge clk);
    check("full_occupancy_valid", 64'(vld_o), 64'd1);
    check("full_occupancy_ready", 64'(rdy_o), 64'd0);
    @(posedge clk);
    #1 rdy_i = 1'b1;
    drain();

    // Reset asynchronously between edges with two ops in flight
    send_model(32'h0F0F_1234, 5'd8, 3'b100, 4'h5);
    send_model(32'hF0F0_4321, 5'd9, 3'b001, 4'h6);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(vld_o), 64'd0);
    check("async_rst_g", 64'(g_o), 64'd0);
    check("async_rst_tag", 64'(tag_o), 64'd0);
    sb.delete();
    n0 = n_out;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check("rst_release_ready", 64'(rdy_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) check("no_stale_valid", 64'(vld_o), 64'd0);
    end
    check("no_stale_count", 64'(n_out - n0), 64'd0);
    @(posedge clk);
    #1;
    send_model(32'h7E93_C2A1, 5'd12, 3'b100, 4'h7);
    drain();

    // Random ops under random backpressure
    rand_done = 1'b0;
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 24; i++)
          send_model($urandom(), LW'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), TW'(i));
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk);
        #1 rdy_i = 1'($urandom_range(0, 1));
      end
    join
    rdy_i = 1'b1;
    drain();
    check("random_out_count", 64'(n_out - n0), 64'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
